// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - framebuffer geometry, default 640x480@60 timing and address helper
package vga_fb_pkg;
  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int FB_ADDR_W = 15;
  localparam int COLOUR_W  = 18;
  localparam int CNT_W     = 10;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb_t;

  // y*160 + x without a multiplier: y*128 + y*32 + x
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    logic [FB_ADDR_W-1:0] yw;
    yw = {{(FB_ADDR_W-7){1'b0}}, y};
    return (yw << 7) + (yw << 5) + {{(FB_ADDR_W-8){1'b0}}, x};
  endfunction
endpackage

// File: rtl/vga_framebuffer_ctrl_timing.sv
// rtl/vga_framebuffer_ctrl_timing.sv - pixel enable, raster counters, raw sync/visible flags, frame pulse
module vga_timing_gen
  import vga_fb_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic             clock,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             vis,
  output logic             frame_start
);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] FS_PREV  = CNT_W'(V_VIS + V_FP - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_en      <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= 1'b0;
      if (pix_en) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
          // lands on the same edge that moves vcount into the sync band
          frame_start <= (vcount == FS_PREV);
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

  assign hs_raw = !((hcount >= HS_START) && (hcount < HS_END));
  assign vs_raw = !((vcount >= VS_START) && (vcount < VS_END));
  assign vis    = (hcount < H_VIS_C) && (vcount < V_VIS_C);
endmodule

// File: rtl/vga_framebuffer_ctrl.sv
// rtl/vga_framebuffer_ctrl.sv - pixel-write front end and 4x-scaled VGA scan-out of a 160x120 framebuffer
module vga_framebuffer_ctrl
  import vga_fb_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           vga_x,
  input  logic [6:0]           vga_y,
  input  logic [COLOUR_W-1:0]  vga_colour,
  input  logic                 vga_write,
  output logic                 fb_wr_en,
  output logic [FB_ADDR_W-1:0] fb_wr_addr,
  output logic [COLOUR_W-1:0]  fb_wr_data,
  output logic [FB_ADDR_W-1:0] fb_rd_addr,
  input  logic [COLOUR_W-1:0]  fb_rd_data,
  output logic [5:0]           vga_r,
  output logic [5:0]           vga_g,
  output logic [5:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic                 frame_start
);
  localparam logic [7:0] X_LIM = 8'(FB_W);
  localparam logic [6:0] Y_LIM = 7'(FB_H);

  logic             pix_en;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hs_raw;
  logic             vs_raw;
  logic             vis;
  logic             wr_ok;
  rgb_t             px;
  logic             unused_cnt_bits;

  vga_timing_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .pix_en      (pix_en),
    .hcount      (hcount),
    .vcount      (vcount),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .vis         (vis),
    .frame_start (frame_start)
  );

  assign wr_ok = vga_write && (vga_x < X_LIM) && (vga_y < Y_LIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
    end else begin
      fb_wr_en <= wr_ok;
      if (wr_ok) begin
        fb_wr_addr <= fb_addr(vga_x, vga_y);
        fb_wr_data <= vga_colour;
      end
    end
  end

  // Blanking reads are parked at 0 so the address never leaves the RAM
  assign fb_rd_addr      = vis ? fb_addr(hcount[9:2], vcount[8:2]) : '0;
  assign unused_cnt_bits = ^{hcount[1:0], vcount[9], vcount[1:0]};

  assign px = rgb_t'(fb_rd_data);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pix_en) begin
      vga_r       <= vis ? px.r : 6'd0;
      vga_g       <= vis ? px.g : 6'd0;
      vga_b       <= vis ? px.b : 6'd0;
      vga_hs      <= hs_raw;
      vga_vs      <= vs_raw;
      vga_blank_n <= vis;
    end
  end
endmodule
